vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator: consumes the hsync/vsync/de/RGB stream that the top level drives out, recovers pixel coordinates, checks line and frame timing against the 640x480 mode, and reports lock status and timing errors. It sits beside the display path as an on-chip monitor and loopback checker, and is also the reference decoder for verification benches.

---
 rtl/vga_sync_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a VGA sync/de stream and checks mode timing.
// Optional pixel colour probe is built only when VGA_DEC_PROBE_EN is defined.
module vga_sync_decoder #(
    parameter int   H_ACTIVE = 640,
    parameter int   V_ACTIVE = 480,
    parameter int   H_TOTAL  = 800,
    parameter int   V_TOTAL  = 525,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    input  logic [5:0] rgb,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [5:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_cnt,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic [5:0] probe_rgb,
    output logic       probe_hit
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] WD_LAST = 12'(2 * H_TOTAL - 1);
    localparam logic [10:0] V_LINES = 11'(V_TOTAL);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);

    state_t      state, state_nx;
    logic        s_hs, s_vs;
    logic        hs_on, vs_on, vs_lead_in;
    logic        hs_lead, de_rise, de_fall, y_pend;
    logic [11:0] h_cnt;
    logic        h_seen, frame_bad;
    logic [10:0] line_cnt, act_lines;
    logic        line_err, frame_err, wd_trip, clr, inc;

    assign hs_on      = (hsync == SYNC_POL);
    assign vs_on      = (vsync == SYNC_POL);
    assign vs_lead_in = vs_on & (s_vs != SYNC_POL);

    // Edge flags are registered so they line up with pix_* and frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hs        <= ~SYNC_POL;
            s_vs        <= ~SYNC_POL;
            hs_lead     <= 1'b0;
            frame_start <= 1'b0;
            de_rise     <= 1'b0;
            de_fall     <= 1'b0;
            pix_valid   <= 1'b0;
            pix_rgb     <= '0;
        end else begin
            s_hs        <= hsync;
            s_vs        <= vsync;
            hs_lead     <= hs_on & (s_hs != SYNC_POL);
            frame_start <= vs_lead_in;
            de_rise     <= de & ~pix_valid;
            de_fall     <= ~de & pix_valid;
            pix_valid   <= de;
            pix_rgb     <= de ? rgb : 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x  <= '0;
            pix_y  <= '0;
            y_pend <= 1'b0;
        end else begin
            y_pend <= (y_pend | vs_lead_in) & ~(de & ~pix_valid);
            if (de && !pix_valid) begin
                pix_x <= '0;
                if (y_pend || vs_lead_in)
                    pix_y <= '0;
                else if (pix_y != '1)
                    pix_y <= pix_y + 10'd1;
            end else if (de && pix_x != '1) begin
                pix_x <= pix_x + 10'd1;
            end
        end
    end

    // pix_x still holds the last column of the run when de_fall is seen.
    always_comb begin
        line_err = 1'b0;
        if (de_fall && pix_x != X_LAST)
            line_err = 1'b1;
        if (hs_lead && h_seen && h_cnt != H_LAST)
            line_err = 1'b1;
    end

    assign frame_err = frame_bad | line_err |
                       (line_cnt != V_LINES) | (act_lines != V_ACT);
    assign wd_trip   = (state != SEARCH) & ~hs_lead & (h_cnt == WD_LAST);

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        inc      = 1'b0;
        unique case (state)
            SEARCH: begin
                if (frame_start) begin
                    state_nx = CHECK;
                    clr      = 1'b1;
                end
            end
            CHECK: begin
                if (frame_start) begin
                    if (frame_err) begin
                        inc = 1'b1;
                        clr = 1'b1;
                    end else begin
                        state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (frame_start && frame_err) begin
                    inc      = 1'b1;
                    state_nx = CHECK;
                end
            end
            default: state_nx = SEARCH;
        endcase
        if (wd_trip) begin
            state_nx = SEARCH;
            inc      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_cnt   <= '0;
            h_cnt     <= '0;
            h_seen    <= 1'b0;
            line_cnt  <= '0;
            act_lines <= '0;
            frame_bad <= 1'b0;
        end else begin
            state  <= state_nx;
            locked <= (state_nx == LOCKED);
            if (inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (clr || hs_lead)
                h_cnt <= '0;
            else if (h_cnt != '1)
                h_cnt <= h_cnt + 12'd1;
            if (clr)
                h_seen <= 1'b0;
            else if (hs_lead)
                h_seen <= 1'b1;
            if (frame_start) begin
                line_cnt  <= {10'd0, hs_lead};
                act_lines <= {10'd0, de_rise};
                frame_bad <= 1'b0;
            end else begin
                if (hs_lead && line_cnt != '1)
                    line_cnt <= line_cnt + 11'd1;
                if (de_rise && act_lines != '1)
                    act_lines <= act_lines + 11'd1;
                if (line_err)
                    frame_bad <= 1'b1;
            end
        end
    end

`ifdef VGA_DEC_PROBE_EN
    logic probe_match;
    assign probe_match = pix_valid & (pix_x == probe_x) & (pix_y == probe_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_rgb <= '0;
            probe_hit <= 1'b0;
        end else begin
            probe_hit <= probe_match;
            if (probe_match)
                probe_rgb <= pix_rgb;
        end
    end
`else
    logic unused_probe;
    assign unused_probe = ^{probe_x, probe_y};
    assign probe_rgb    = '0;
    assign probe_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench for a reduced VGA mode with a frame-level reference model.
// Covers lock/relock, short line, hsync watchdog, mid-frame reset and the optional probe.
module tb_vga_sync_decoder;
    localparam int HA = 16;
    localparam int VA = 10;
    localparam int HT = 24;
    localparam int VT = 14;
    localparam int HS_BEG = 18;
    localparam int HS_END = 21;
    localparam int VS_LINES = 2;
    localparam int V_FIRST = 4;
    localparam int PX = 5;
    localparam int PY = 3;
    localparam logic ACT = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       hsync, vsync, de;
    logic [5:0] rgb;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [5:0] pix_rgb;
    logic       frame_start, locked;
    logic [7:0] err_cnt;
    logic [9:0] probe_x, probe_y;
    logic [5:0] probe_rgb;
    logic       probe_hit;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .SYNC_POL(ACT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt),
        .probe_x(probe_x), .probe_y(probe_y), .probe_rgb(probe_rgb), .probe_hit(probe_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] c;
    } pix_t;

    typedef struct packed {
        logic       lk;
        logic [7:0] err;
    } st_t;

    pix_t pix_q[$];
    st_t  st_q[$];

    int total = 0;
    int bad = 0;

    // reference model state
    bit m_search = 1'b1;
    bit m_locked = 1'b0;
    int m_err = 0;
    int cyc = 0;
    int last_hs = -1;
    bit p_hs = 1'b0, p_vs = 1'b0, p_de = 1'b0;
    int run = 0, runs = 0, f_hs = 0, f_lines = 0;
    bit f_bad = 1'b0;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_x"}, pix_x, 0);
        chk({tag, "_y"}, pix_y, 0);
        chk({tag, "_rgb"}, pix_rgb, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_prgb"}, probe_rgb, 0);
        chk({tag, "_phit"}, probe_hit, 0);
    endtask

    task automatic model_reset();
        m_search = 1'b1;
        m_locked = 1'b0;
        m_err = 0;
        last_hs = -1;
        p_hs = 1'b0;
        p_vs = 1'b0;
        p_de = 1'b0;
        run = 0;
        runs = 0;
        f_hs = 0;
        f_lines = 0;
        f_bad = 1'b0;
    endtask

    task automatic drive(bit hs_on, bit vs_on, bit d, logic [5:0] c);
        bit   hs_edge;
        bit   good;
        pix_t p;
        st_t  s;
        hsync = hs_on ? ACT : ~ACT;
        vsync = vs_on ? ACT : ~ACT;
        de = d;
        rgb = c;
        hs_edge = hs_on && !p_hs;
        if (!m_search && last_hs >= 0 && !hs_edge && cyc - last_hs == 2 * HT) begin
            m_search = 1'b1;
            m_locked = 1'b0;
            if (m_err < 255) m_err++;
        end
        if (p_de && !d && run != HA) f_bad = 1'b1;
        if (hs_edge && last_hs >= 0 && cyc - last_hs != HT) f_bad = 1'b1;
        if (vs_on && !p_vs) begin
            good = !f_bad && f_hs == VT && f_lines == VA;
            if (m_search) begin
                m_search = 1'b0;
                m_locked = 1'b0;
            end else if (good) begin
                m_locked = 1'b1;
            end else begin
                m_locked = 1'b0;
                if (m_err < 255) m_err++;
            end
            s.lk = m_locked;
            s.err = 8'(m_err);
            st_q.push_back(s);
            f_bad = 1'b0;
            f_hs = 0;
            f_lines = 0;
            runs = 0;
        end
        if (hs_edge) begin
            f_hs++;
            last_hs = cyc;
        end
        if (d) begin
            if (!p_de) begin
                run = 0;
                runs++;
                f_lines++;
            end
            p.x = 10'((run > 1023) ? 1023 : run);
            p.y = 10'((runs - 1 > 1023) ? 1023 : runs - 1);
            p.c = c;
            pix_q.push_back(p);
            run++;
        end
        p_hs = hs_on;
        p_vs = vs_on;
        p_de = d;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pick(int row, int col);
        if (row == 0 && col == 0) return 6'b111110;
        if (row == VA - 1 && col == HA - 1) return 6'b000001;
        if (row == PY && col == PX) return 6'b010000;
        return 6'($urandom);
    endfunction

    task automatic send_frame(int short_line, int drop_line, int n_lines);
        int len;
        bit hs_on, vs_on, d;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                hs_on = (c >= HS_BEG && c < HS_END) &&
                        !(drop_line >= 0 && (l == drop_line || l == drop_line + 1));
                vs_on = (l < VS_LINES);
                d = (l >= V_FIRST) && (c < HA);
                drive(hs_on, vs_on, d, d ? pick(l - V_FIRST, c) : 6'($urandom));
            end
        end
    endtask

    // monitor / scoreboard
    bit         st_pend = 1'b0;
    st_t        st_exp;
    bit         pr_pend = 1'b0;
    logic [5:0] pr_exp;
    pix_t       pe;

    initial begin
        forever begin
            @(negedge clk);
            if (st_pend) begin
                chk("locked", locked, st_exp.lk);
                chk("err_cnt", err_cnt, st_exp.err);
                st_pend = 1'b0;
            end
`ifdef VGA_DEC_PROBE_EN
            if (pr_pend) begin
                chk("probe_hit", probe_hit, 1);
                chk("probe_rgb", probe_rgb, pr_exp);
            end else begin
                chk("probe_idle", probe_hit, 0);
            end
            pr_pend = 1'b0;
`else
            chk("probe_off", {probe_hit, probe_rgb}, 0);
`endif
            if (frame_start) begin
                if (st_q.size() == 0) begin
                    chk("frame_start_extra", 1, 0);
                end else begin
                    st_exp = st_q.pop_front();
                    st_pend = 1'b1;
                end
            end
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pix_extra", 1, 0);
                end else begin
                    pe = pix_q.pop_front();
                    chk("pix_x", pix_x, pe.x);
                    chk("pix_y", pix_y, pe.y);
                    chk("pix_rgb", pix_rgb, pe.c);
                    if (pe.x == PX && pe.y == PY) begin
                        pr_pend = 1'b1;
                        pr_exp = pe.c;
                    end
                end
            end else begin
                chk("rgb_blank", pix_rgb, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        hsync = ~ACT;
        vsync = ~ACT;
        de = 1'b0;
        rgb = '0;
        probe_x = 10'(PX);
        probe_y = 10'(PY);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst0");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst0b");
        rst_n = 1'b1;
        model_reset();

        repeat (3) send_frame(-1, -1, VT);
        send_frame(int'($urandom_range(5, 11)), -1, VT);
        send_frame(-1, -1, VT);
        send_frame(-1, -1, VT);

        send_frame(-1, int'($urandom_range(5, 10)), VT);
        chk("wd_locked", locked, 0);
        chk("wd_err", err_cnt, m_err);
        send_frame(-1, -1, VT);
        send_frame(-1, -1, VT);

        send_frame(-1, -1, int'($urandom_range(5, 12)));
        rst_n = 1'b0;
        hsync = ~ACT;
        vsync = ~ACT;
        de = 1'b0;
        #1;
        check_zero("rst1");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst1b");
        rst_n = 1'b1;
        model_reset();

        repeat (3) send_frame(-1, -1, VT);
        send_frame(-1, -1, 1);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 6'd0);

        chk("pix_q_left", pix_q.size(), 0);
        chk("st_q_left", st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
